// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand request, result response
// and the per-bit trace that is visible while a subtraction is in progress.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             bit_valid;
  logic             bit_diff;
  logic             bit_borrow;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, bit_valid, bit_diff, bit_borrow
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, bit_valid, bit_diff, bit_borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor bit per clock,
// LSB first, borrow carried in a register between bits.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] diffShift_q;
  logic [WIDTH-1:0] diffShift_d;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] count_q;
  logic             borrow_q;
  logic             borrowOut_q;
  logic             inReady_q;
  logic             outValid_q;
  logic             running;
  logic             ai;
  logic             bi;
  logic             bitDiff;
  logic             bitBorrow;

  // Operands shift right each RUN cycle so the current bit is always at index 0.
  assign running = (state_q == RUN);
  assign ai      = aShift_q[0];
  assign bi      = bShift_q[0];

  always_comb begin
    bitDiff     = 1'b0;
    bitBorrow   = 1'b0;
    if (running) begin
      bitDiff   = ai ^ bi ^ borrow_q;
      bitBorrow = (~ai & bi) | (~(ai ^ bi) & borrow_q);
    end
    diffShift_d = (diffShift_q >> 1) | (WIDTH'(bitDiff) << (WIDTH - 1));
  end

  // diff_q only updates on completion, so the previous result stays visible during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      diffShift_q <= '0;
      diff_q      <= '0;
      count_q     <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            aShift_q  <= bus.a;
            bShift_q  <= bus.b;
            borrow_q  <= 1'b0;
            count_q   <= '0;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          aShift_q    <= aShift_q >> 1;
          bShift_q    <= bShift_q >> 1;
          diffShift_q <= diffShift_d;
          borrow_q    <= bitBorrow;
          count_q     <= count_q + 1'b1;
          if (count_q == LAST) begin
            diff_q      <= diffShift_d;
            borrowOut_q <= bitBorrow;
            outValid_q  <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = inReady_q;
  assign bus.out_valid  = outValid_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrowOut_q;
  assign bus.bit_valid  = running;
  assign bus.bit_diff   = bitDiff;
  assign bus.bit_borrow = bitBorrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus hand-written
// sequences for back-pressure, ignored requests, bit trace and mid-run reset.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expDiff;
    logic       expBorrow;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] prevDiff = 8'h00;
  vec_t vecs [10];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge (RUN cycle 0).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    int waited = 0;
    while (!bus.in_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) checkOutput("in_ready wait", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    applyStimulus(v.a, v.b);
    checkOutput({tag, " in_ready low in RUN"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, " bit_valid in RUN"}, 32'(bus.bit_valid), 32'd1);
    checkOutput({tag, " diff held during RUN"}, 32'(bus.diff), 32'(prevDiff));
    waitDone(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd8);
    checkOutput({tag, " diff"}, 32'(bus.diff), 32'(v.expDiff));
    checkOutput({tag, " borrow_out"}, 32'(bus.borrow_out), 32'(v.expBorrow));
    checkOutput({tag, " in_ready low in DONE"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput({tag, " out_valid dropped"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " back in IDLE"}, 32'(bus.in_ready), 32'd1);
    prevDiff = v.expDiff;
  endtask

  initial begin
    int         lat;
    logic [7:0] traceDiff;
    logic [7:0] traceBorrow;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 8'h0F, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 8'h55, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 8'hAB, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[8] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[9] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset diff", 32'(bus.diff), 32'd0);
    checkOutput("reset borrow_out", 32'(bus.borrow_out), 32'd0);
    checkOutput("reset bit_valid", 32'(bus.bit_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] bit trace 0x03-0x05");
    traceDiff   = 8'hFE;
    traceBorrow = 8'hFC;
    applyStimulus(8'h03, 8'h05);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("trace bit_valid %0d", i), 32'(bus.bit_valid), 32'd1);
      checkOutput($sformatf("trace bit_diff %0d", i), 32'(bus.bit_diff), 32'(traceDiff[i]));
      checkOutput($sformatf("trace bit_borrow %0d", i), 32'(bus.bit_borrow),
                  32'(traceBorrow[i]));
      @(negedge clk);
    end
    checkOutput("trace out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("trace diff", 32'(bus.diff), 32'hFE);
    checkOutput("trace borrow_out", 32'(bus.borrow_out), 32'd1);
    checkOutput("trace bit_valid in DONE", 32'(bus.bit_valid), 32'd0);
    @(negedge clk);
    prevDiff = 8'hFE;

    $display("[TB] back-pressure 0x80-0x01");
    bus.out_ready = 1'b0;
    applyStimulus(8'h80, 8'h01);
    waitDone(lat);
    checkOutput("hold latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold out_valid %0d", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("hold diff %0d", i), 32'(bus.diff), 32'h7F);
      checkOutput($sformatf("hold borrow %0d", i), 32'(bus.borrow_out), 32'd0);
      checkOutput($sformatf("hold in_ready %0d", i), 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold out_valid dropped", 32'(bus.out_valid), 32'd0);
    checkOutput("hold diff kept", 32'(bus.diff), 32'h7F);

    $display("[TB] request during RUN ignored");
    applyStimulus(8'h20, 8'h05);
    repeat (2) @(negedge clk);
    bus.a        = 8'hAA;
    bus.b        = 8'hBB;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    waitDone(lat);
    checkOutput("ignore latency", 32'(lat), 32'd5);
    checkOutput("ignore diff", 32'(bus.diff), 32'h1B);
    checkOutput("ignore borrow_out", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    checkOutput("ignore out_valid dropped", 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("ignore no second op", 32'(bus.in_ready), 32'd1);

    $display("[TB] reset during RUN");
    applyStimulus(8'h33, 8'h44);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort diff", 32'(bus.diff), 32'd0);
    checkOutput("abort borrow_out", 32'(bus.borrow_out), 32'd0);
    checkOutput("abort bit_valid", 32'(bus.bit_valid), 32'd0);
    checkOutput("abort bit_diff", 32'(bus.bit_diff), 32'd0);
    checkOutput("abort bit_borrow", 32'(bus.bit_borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("abort no result", 32'(bus.out_valid), 32'd0);
    checkOutput("abort idle", 32'(bus.in_ready), 32'd1);
    prevDiff = 8'h00;
    runVector('{8'h10, 8'h01, 8'h0F, 1'b0}, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
